// File: rtl/sha3_sponge_ctrl.sv
// Sponge sequencer for the SHA3-512 core: clears the state, alternates absorb and
// Keccak-f permutation rounds until the padded final block is folded in, then flags the digest.
module sha3_sponge_ctrl #(
  parameter int RATE_BYTES   = 72,
  parameter int PERM_TIMEOUT = 1023,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             msg_last,
  input  logic             buf_empty,
  input  logic             abs_done,
  input  logic [6:0]       abs_count,
  input  logic             perm_done,
  output logic             abs_go,
  output logic             abs_kill,
  output logic             abs_data_done,
  output logic             perm_go,
  output logic [1:0]       state_sel,
  output logic             state_clear,
  output logic             busy,
  output logic             digest_valid,
  output logic [CNT_W-1:0] block_count,
  output logic             error
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ABSORB, S_WAIT_ABS, S_PERMUTE, S_WAIT_PERM, S_DONE, S_ERROR
  } state_t;

  localparam logic [1:0] SEL_HOLD = 2'd0;
  localparam logic [1:0] SEL_ABS  = 2'd1;
  localparam logic [1:0] SEL_PERM = 2'd2;

  localparam int             WD_W     = $clog2(PERM_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(PERM_TIMEOUT - 1);
  localparam logic [7:0]      RATE_LIM = 8'(RATE_BYTES);

  state_t          state;
  logic            final_q;
  logic [WD_W-1:0] wd_cnt;

  // abs_data_done doubles as the sticky last-byte flag handed to the absorber for padding.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every branch reads pre-edge values.
    if (!rst) begin
      state         <= S_IDLE;
      final_q       <= 1'b0;
      wd_cnt        <= '0;
      abs_go        <= 1'b0;
      abs_kill      <= 1'b0;
      abs_data_done <= 1'b0;
      perm_go       <= 1'b0;
      state_sel     <= SEL_HOLD;
      state_clear   <= 1'b0;
      busy          <= 1'b0;
      digest_valid  <= 1'b0;
      block_count   <= '0;
      error         <= 1'b0;
    end else begin
      abs_go      <= 1'b0;
      perm_go     <= 1'b0;
      state_clear <= 1'b0;
      abs_kill    <= 1'b0;
      if (abort) begin
        state         <= S_IDLE;
        abs_kill      <= 1'b1;
        abs_data_done <= 1'b0;
        final_q       <= 1'b0;
        block_count   <= '0;
        digest_valid  <= 1'b0;
        error         <= 1'b0;
        busy          <= 1'b0;
        state_sel     <= SEL_HOLD;
      end else begin
        if (busy && msg_last) abs_data_done <= 1'b1;
        unique case (state)
          S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
              state        <= S_CLEAR;
              state_clear  <= 1'b1;
              busy         <= 1'b1;
              block_count  <= '0;
              digest_valid <= 1'b0;
              error        <= 1'b0;
            end
          end
          S_CLEAR: begin
            abs_data_done <= 1'b0;
            final_q       <= 1'b0;
            state         <= S_ABSORB;
            abs_go        <= 1'b1;
          end
          S_ABSORB: begin
            state     <= S_WAIT_ABS;
            state_sel <= SEL_ABS;
          end
          S_WAIT_ABS: begin
            if (abs_done) begin
              state_sel <= SEL_HOLD;
              if ({1'b0, abs_count} > RATE_LIM) begin
                state <= S_ERROR;
                error <= 1'b1;
                busy  <= 1'b0;
              end else begin
                // Final only if the host had already flagged the last byte and nothing is queued.
                final_q <= abs_data_done & buf_empty;
                state   <= S_PERMUTE;
                perm_go <= 1'b1;
              end
            end
          end
          S_PERMUTE: begin
            state     <= S_WAIT_PERM;
            state_sel <= SEL_PERM;
            wd_cnt    <= '0;
          end
          S_WAIT_PERM: begin
            if (perm_done) begin
              state_sel <= SEL_HOLD;
              if (block_count != '1) block_count <= block_count + 1'b1;
              if (final_q) begin
                state        <= S_DONE;
                digest_valid <= 1'b1;
                busy         <= 1'b0;
              end else begin
                state  <= S_ABSORB;
                abs_go <= 1'b1;
              end
            end else if (wd_cnt == WD_LAST) begin
              state     <= S_ERROR;
              state_sel <= SEL_HOLD;
              error     <= 1'b1;
              busy      <= 1'b0;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
          end
          default: begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            state_sel <= SEL_HOLD;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha3_sponge_ctrl.sv
// Scenario bench for sha3_sponge_ctrl: output pulses are matched against a scoreboard
// of expected events, with cycle-exact inline checks inside each scenario task.
module tb_sha3_sponge_ctrl;

  localparam int PERM_TIMEOUT = 1023;
  localparam int CNT_W        = 16;

  logic             clk = 1'b0;
  logic             rst, start, abort, msg_last, buf_empty, abs_done, perm_done;
  logic [6:0]       abs_count;
  logic             abs_go, abs_kill, abs_data_done, perm_go, state_clear, busy;
  logic             digest_valid, error;
  logic [1:0]       state_sel;
  logic [CNT_W-1:0] block_count;

  int checks   = 0;
  int failures = 0;

  typedef enum int {EV_CLEAR, EV_ABS_GO, EV_PERM_GO, EV_DONE, EV_ERR, EV_KILL} ev_e;
  typedef struct {
    ev_e kind;
    int  bc;
  } ev_t;

  ev_t exp_q[$];
  ev_e mon_seen[$];
  logic dv_q  = 1'b0;
  logic err_q = 1'b0;

  sha3_sponge_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .msg_last(msg_last),
    .buf_empty(buf_empty), .abs_done(abs_done), .abs_count(abs_count),
    .perm_done(perm_done), .abs_go(abs_go), .abs_kill(abs_kill),
    .abs_data_done(abs_data_done), .perm_go(perm_go), .state_sel(state_sel),
    .state_clear(state_clear), .busy(busy), .digest_valid(digest_valid),
    .block_count(block_count), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "bench timed out");
  end

  // Every observed output event must match the oldest outstanding expectation.
  always @(negedge clk) begin
    mon_seen.delete();
    if (state_clear)            mon_seen.push_back(EV_CLEAR);
    if (abs_go)                 mon_seen.push_back(EV_ABS_GO);
    if (perm_go)                mon_seen.push_back(EV_PERM_GO);
    if (abs_kill)               mon_seen.push_back(EV_KILL);
    if (digest_valid && !dv_q)  mon_seen.push_back(EV_DONE);
    if (error && !err_q)        mon_seen.push_back(EV_ERR);
    foreach (mon_seen[i]) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard: unexpected %s at %0t (bc=%0d), expected no event",
                 mon_seen[i].name(), $time, block_count);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.kind !== mon_seen[i] || e.bc !== int'(block_count)) begin
          failures++;
          $display("FAIL scoreboard: got %s bc=%0d at %0t, expected %s bc=%0d",
                   mon_seen[i].name(), block_count, $time, e.kind.name(), e.bc);
        end
      end
    end
    dv_q  = digest_valid;
    err_q = error;
  end

  function automatic void push(input ev_e k, input int bc);
    exp_q.push_back('{kind: k, bc: bc});
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // From IDLE/DONE/ERROR at a negedge; returns at the negedge of the ABSORB cycle.
  task automatic begin_hash(input string tag);
    push(EV_CLEAR, 0);
    push(EV_ABS_GO, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (state_clear !== 1'b1 || block_count !== '0) begin
      failures++;
      $display("FAIL %s_clear: state_clear=%b block_count=%0d, expected 1 and 0",
               tag, state_clear, block_count);
    end
    tick();
    checks++;
    if (abs_go !== 1'b1) begin
      failures++;
      $display("FAIL %s_abs_go: abs_go=%b, expected 1", tag, abs_go);
    end
  endtask

  // One-cycle abs_done pulse driven from a WAIT_ABS negedge.
  task automatic pulse_abs(input logic [6:0] cnt, input logic empty, input logic last_now);
    abs_done  = 1'b1;
    abs_count = cnt;
    buf_empty = empty;
    msg_last  = last_now;
    tick();
    abs_done = 1'b0;
    msg_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(2);
    checks++;
    if ({abs_go, abs_kill, abs_data_done, perm_go, state_sel, state_clear, busy,
         digest_valid, block_count, error} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b sel=%0d bc=%0d err=%b dv=%b, expected all 0",
               busy, state_sel, block_count, error, digest_valid);
    end
    rst = 1'b1;
    tick(3);
    checks++;
    if ({abs_go, abs_kill, abs_data_done, perm_go, state_sel, state_clear, busy,
         digest_valid, block_count, error} !== '0) begin
      failures++;
      $display("FAIL idle_outputs: busy=%b sel=%0d bc=%0d err=%b dv=%b, expected all 0",
               busy, state_sel, block_count, error, digest_valid);
    end
  endtask

  task automatic test_short();
    begin_hash("short");
    msg_last = 1'b1;
    tick();
    msg_last = 1'b0;
    checks++;
    if (abs_data_done !== 1'b1 || state_sel !== 2'd1) begin
      failures++;
      $display("FAIL short_last: abs_data_done=%b state_sel=%0d, expected 1 and 1",
               abs_data_done, state_sel);
    end
    push(EV_PERM_GO, 0);
    pulse_abs(7'd5, 1'b1, 1'b0);
    checks++;
    if (perm_go !== 1'b1) begin
      failures++;
      $display("FAIL short_perm_go: perm_go=%b, expected 1", perm_go);
    end
    push(EV_DONE, 1);
    abs_done = 1'b1;  // outside WAIT_ABS: must be ignored
    tick();
    abs_done = 1'b0;
    tick(22);
    checks++;
    if (state_sel !== 2'd2 || digest_valid !== 1'b0) begin
      failures++;
      $display("FAIL short_wait_perm: state_sel=%0d digest_valid=%b, expected 2 and 0",
               state_sel, digest_valid);
    end
    perm_done = 1'b1;
    tick();
    perm_done = 1'b0;
    checks++;
    if (digest_valid !== 1'b1 || block_count !== 16'd1 || busy !== 1'b0 || state_sel !== 2'd0) begin
      failures++;
      $display("FAIL short_done: dv=%b bc=%0d busy=%b sel=%0d, expected 1 1 0 0",
               digest_valid, block_count, busy, state_sel);
    end
    tick(3);
    checks++;
    if (digest_valid !== 1'b1) begin
      failures++;
      $display("FAIL short_hold: digest_valid=%b, expected 1", digest_valid);
    end
    buf_empty = 1'b0;
  endtask

  task automatic test_three_block();
    begin_hash("three");
    tick();
    start = 1'b1;  // busy: ignored
    tick();
    start = 1'b0;
    checks++;
    if (state_clear !== 1'b0 || state_sel !== 2'd1) begin
      failures++;
      $display("FAIL three_busy_start: state_clear=%b state_sel=%0d, expected 0 and 1",
               state_clear, state_sel);
    end
    for (int b = 0; b < 3; b++) begin
      checks++;
      if (abs_data_done !== (b == 2)) begin
        failures++;
        $display("FAIL three_last_b%0d: abs_data_done=%b, expected %0d", b, abs_data_done, b == 2);
      end
      push(EV_PERM_GO, b);
      // msg_last coincides with the second abs_done, so it only marks the third block final.
      pulse_abs(7'd72, b >= 1, b == 1);
      checks++;
      if (perm_go !== 1'b1) begin
        failures++;
        $display("FAIL three_perm_go_b%0d: perm_go=%b, expected 1", b, perm_go);
      end
      if (b == 0) perm_done = 1'b1;  // coincident with perm_go: ignored
      tick();
      perm_done = 1'b0;
      checks++;
      if (state_sel !== 2'd2) begin
        failures++;
        $display("FAIL three_wait_b%0d: state_sel=%0d, expected 2", b, state_sel);
      end
      if (b < 2) push(EV_ABS_GO, b + 1);
      else       push(EV_DONE, 3);
      tick(5);
      perm_done = 1'b1;
      tick();
      perm_done = 1'b0;
      checks++;
      if (block_count !== CNT_W'(b + 1) || digest_valid !== (b == 2) || abs_go !== (b < 2)) begin
        failures++;
        $display("FAIL three_perm_b%0d: bc=%0d dv=%b abs_go=%b, expected %0d %0d %0d",
                 b, block_count, digest_valid, abs_go, b + 1, b == 2, b < 2);
      end
      if (b < 2) tick();
    end
    buf_empty = 1'b0;
  endtask

  task automatic test_watchdog();
    int cnt;
    begin_hash("wd");
    tick();
    push(EV_PERM_GO, 0);
    pulse_abs(7'd72, 1'b0, 1'b0);
    checks++;
    if (perm_go !== 1'b1 || error !== 1'b0) begin
      failures++;
      $display("FAIL wd_rate_boundary: perm_go=%b error=%b, expected 1 and 0", perm_go, error);
    end
    push(EV_ERR, 0);
    cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (state_sel == 2'd2) cnt++;
      else break;
    end
    checks++;
    if (cnt != PERM_TIMEOUT || error !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL wd_fire: wait_perm cycles=%0d error=%b busy=%b, expected %0d 1 0",
               cnt, error, busy, PERM_TIMEOUT);
    end
    begin_hash("wd_restart");
    checks++;
    if (error !== 1'b0) begin
      failures++;
      $display("FAIL wd_restart_err: error=%b, expected 0", error);
    end
  endtask

  // Continues from the ABSORB cycle left by test_watchdog.
  task automatic test_abort();
    tick();
    push(EV_PERM_GO, 0);
    pulse_abs(7'd10, 1'b0, 1'b0);
    push(EV_ABS_GO, 1);
    tick();
    perm_done = 1'b1;
    tick();
    perm_done = 1'b0;
    tick();
    push(EV_PERM_GO, 1);
    pulse_abs(7'd20, 1'b0, 1'b1);
    tick();
    push(EV_KILL, 0);
    abort     = 1'b1;
    perm_done = 1'b1;
    tick();
    abort     = 1'b0;
    perm_done = 1'b0;
    checks++;
    if (abs_kill !== 1'b1 || busy !== 1'b0 || block_count !== '0 || digest_valid !== 1'b0 ||
        state_sel !== 2'd0 || abs_data_done !== 1'b0) begin
      failures++;
      $display("FAIL abort_state: kill=%b busy=%b bc=%0d dv=%b sel=%0d last=%b, expected 1 0 0 0 0 0",
               abs_kill, busy, block_count, digest_valid, state_sel, abs_data_done);
    end
    tick();
    checks++;
    if (abs_kill !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_pulse: abs_kill=%b busy=%b, expected 0 and 0", abs_kill, busy);
    end
  endtask

  task automatic test_bad_count();
    begin_hash("bad");
    tick();
    push(EV_ERR, 0);
    pulse_abs(7'd100, 1'b0, 1'b0);
    checks++;
    if (error !== 1'b1 || perm_go !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bad_count: error=%b perm_go=%b busy=%b, expected 1 0 0", error, perm_go, busy);
    end
    push(EV_KILL, 0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (state_clear !== 1'b0 || error !== 1'b0 || abs_kill !== 1'b1) begin
      failures++;
      $display("FAIL abort_beats_start: state_clear=%b error=%b abs_kill=%b, expected 0 0 1",
               state_clear, error, abs_kill);
    end
    tick(2);
    checks++;
    if (busy !== 1'b0 || abs_go !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: busy=%b abs_go=%b, expected 0 and 0", busy, abs_go);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; msg_last = 1'b0; buf_empty = 1'b0;
    abs_done = 1'b0; abs_count = '0; perm_done = 1'b0;
    test_reset();
    test_short();
    test_three_block();
    test_watchdog();
    test_abort();
    test_bad_count();
    tick(2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expected events never seen, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
